// File: rtl/sirv_mrom_copier_pkg.sv
// Shared types and constants for the mask-ROM boot copier: FSM encoding and ICB field widths.
package sirv_mrom_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CMD   = 3'd2,
    ST_RSP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;
  localparam int ICB_MW = ICB_DW / 8;

  localparam logic [ICB_MW-1:0] WMASK_FULL = 4'hF;

  // Index counter width; a single-word copy still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sirv_mrom.sv
// Mask ROM holding the boot stub (auipc t0,0x7ffff; jr t0); combinational word read port.
// Words beyond the two-instruction stub, and addresses at or past DP, read as zero.
module sirv_mrom #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int DP = 1024
) (
  input  logic [AW-1:2] rom_addr,
  output logic [DW-1:0] rom_dout
);

  always_comb begin
    rom_dout = '0;
    if (32'(rom_addr) < DP) begin
      case (32'(rom_addr))
        32'd0:   rom_dout = DW'(32'h7ffff297);
        32'd1:   rom_dout = DW'(32'h00028067);
        default: rom_dout = '0;
      endcase
    end
  end

endmodule

// File: rtl/sirv_mrom_copier.sv
// Boot copy engine: reads ROM words from 0 and writes each to DST_BASE + 4*index over ICB.
// Three cycles per word at zero wait; low cmd_ready / rsp_valid stretches CMD / RSP, one command outstanding.
module sirv_mrom_copier
  import sirv_mrom_copier_pkg::*;
#(
  parameter int          AW         = 12,
  parameter int          DW         = 32,
  parameter int          DP         = 1024,
  parameter int          COPY_WORDS = 1024,
  parameter logic [31:0] DST_BASE   = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [AW-3:0]     rom_addr,
  input  logic [DW-1:0]     rom_dout,
  output logic              icb_cmd_valid,
  input  logic              icb_cmd_ready,
  output logic [ICB_AW-1:0] icb_cmd_addr,
  output logic              icb_cmd_read,
  output logic [DW-1:0]     icb_cmd_wdata,
  output logic [DW/8-1:0]   icb_cmd_wmask,
  input  logic              icb_rsp_valid,
  output logic              icb_rsp_ready,
  input  logic              icb_rsp_err,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int            IW       = idx_width(COPY_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(COPY_WORDS - 1);

  if (COPY_WORDS < 1 || COPY_WORDS > DP || DW != 32 || DST_BASE[1:0] != 2'b00) begin : g_bad_param
    $error("sirv_mrom_copier: illegal COPY_WORDS, DW or DST_BASE");
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ICB_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        // Command fields are frozen here so they stay put through any CMD stall.
        wdata_d = rom_dout;
        addr_d  = DST_BASE + (ICB_AW'(idx_q) << 2);
        state_d = ST_CMD;
      end
      ST_CMD: begin
        if (icb_cmd_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    icb_cmd_valid = (state_q == ST_CMD);
    icb_rsp_ready = (state_q == ST_RSP);
    busy          = (state_q == ST_FETCH) || (state_q == ST_CMD) || (state_q == ST_RSP);
    icb_cmd_wmask = icb_cmd_valid ? WMASK_FULL : '0;
  end

  assign rom_addr      = (AW-2)'(idx_q);
  assign icb_cmd_addr  = addr_q;
  assign icb_cmd_wdata = wdata_q;
  assign icb_cmd_read  = 1'b0;
  assign done          = done_q;
  assign err           = err_q;

endmodule
